sw_debounce_m: RTL



---
 rtl/sw_debounce_m_pkg.sv | 22 ++
 rtl/sw_debounce_m_bit.sv | 79 +++++++
 rtl/sw_debounce_m.sv | 72 +++++++
 3 files changed

// File: rtl/sw_debounce_m_pkg.sv
// Shared types and default parameters for the switch debounce stage.
package sw_debounce_m_pkg;

  // Switch word as consumed by slon5_m.
  typedef logic [7:0] Dnum_t;

  localparam int SW_W_DEF = $bits(Dnum_t);

  // Board defaults: 1 ms sample tick at 100 MHz, 10 ms of stability.
  localparam int TICK_DIV_DEF     = 100000;
  localparam int STABLE_TICKS_DEF = 10;

  // Short timing used in simulation so a full debounce takes a few cycles.
  localparam int TICK_DIV_SIM     = 4;
  localparam int STABLE_TICKS_SIM = 3;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_m_bit.sv
// One switch bit: two-flop synchroniser followed by a tick-based stability filter.
module sw_debounce_bit_m
  import sw_debounce_m_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic upd
);

  localparam int            CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Synchroniser: raw goes straight through two flops, nothing in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Stability filter: any return to the current level discards progress.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        cnt_d   = '0;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  // Next-cycle update strobe, lets the top register sw_evt alongside the pulses.
  assign upd   = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce_m.sv
// Switch debounce stage: shared sample prescaler, per-bit filters, event summary.
module sw_debounce_m
  import sw_debounce_m_pkg::*;
#(
  parameter int              SW_W         = SW_W_DEF,
  parameter int              TICK_DIV     = TICK_DIV_DEF,
  parameter int              STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic [SW_W-1:0] RST_VAL      = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw_raw,
  output logic [SW_W-1:0] sw_q,
  output logic [SW_W-1:0] sw_rise,
  output logic [SW_W-1:0] sw_fall,
  output logic            sw_evt
);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("sw_debounce_m: TICK_DIV must be at least 1");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable_ticks
    $error("sw_debounce_m: STABLE_TICKS must be at least 1");
  end

  localparam int               PRE_W    = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [SW_W-1:0]  upd;
  logic             sw_evt_q, sw_evt_d;

  // With TICK_DIV=1 the prescaler sits at 0 and tick stays high.
  assign tick = (pre_q == PRE_LAST);

  // Prescaler next value and event summary.
  always_comb begin
    pre_d    = tick ? '0 : pre_q + 1'b1;
    sw_evt_d = |upd;
  end

  // Free-running prescaler and registered event flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      sw_evt_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      sw_evt_q <= sw_evt_d;
    end
  end

  for (genvar i = 0; i < SW_W; i++) begin : g_bit
    sw_debounce_bit_m #(
      .STABLE_TICKS(STABLE_TICKS),
      .RST_VAL     (RST_VAL[i])
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .raw  (sw_raw[i]),
      .level(sw_q[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i]),
      .upd  (upd[i])
    );
  end

  assign sw_evt = sw_evt_q;

endmodule
